// File: rtl/spi_req_arbiter_if.sv
// Request/SPI bundle between four requesters, the arbiter and the word serializer.
interface spi_req_arbiter_if;
   logic [3:0]  req;
   logic [63:0] wdata;
   logic [3:0]  ack;
   logic [3:0]  err;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic        spi_start;
   logic [15:0] spi_word;
   logic [1:0]  spi_sel;
   logic        spi_busy;
   logic        spi_done;

   modport slave (
      input  req, wdata, spi_busy, spi_done,
      output ack, err, grant_valid, grant_id, spi_start, spi_word, spi_sel
   );

   modport master (
      output req, wdata, spi_busy, spi_done,
      input  ack, err, grant_valid, grant_id, spi_start, spi_word, spi_sel
   );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter granting one of four requesters a single SPI word transfer,
// with a WAIT timeout and a fixed idle gap between grants.
module spi_req_arbiter #(
   parameter int TIMEOUT_CYC = 64,
   parameter int GAP_CYC     = 2
) (
   input  logic              clk,
   input  logic              rst,
   spi_req_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_ACK   = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

   state_t      r_state, w_next;
   logic [1:0]  r_grant_id, r_last_grant;
   logic [15:0] r_spi_word, r_timer, r_gap_cnt;
   logic        r_err_flag;
   logic [1:0]  w_winner, w_cand;
   logic        w_found, w_any_req, w_timeout, w_gap_done;

   assign w_any_req  = |bus.req;
   assign w_timeout  = (r_timer == TO_LAST);
   assign w_gap_done = (r_gap_cnt == GAP_LAST);

   // Search starts just above the last grantee; k=4 wraps back to it last.
   always_comb begin
      w_winner = r_last_grant;
      w_cand   = r_last_grant;
      w_found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         w_cand = r_last_grant + 2'(k);
         if (!w_found && bus.req[w_cand]) begin
            w_winner = w_cand;
            w_found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_START;
         S_START: if (!bus.spi_busy) w_next = S_WAIT;
         S_WAIT:  if (bus.spi_done || w_timeout) w_next = S_ACK;
         S_ACK:   w_next = (GAP_CYC > 0) ? S_GAP : S_IDLE;
         S_GAP:   if (w_gap_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_id   <= 2'd0;
         r_last_grant <= 2'd3;
         r_spi_word   <= 16'd0;
         r_timer      <= 16'd0;
         r_gap_cnt    <= 16'd0;
         r_err_flag   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any_req) begin
               r_grant_id <= w_winner;
               r_spi_word <= bus.wdata[{w_winner, 4'b0000} +: 16];
               r_err_flag <= 1'b0;
            end
            S_START: if (!bus.spi_busy) r_timer <= 16'd0;
            // spi_done is checked first so it wins over a coincident timeout.
            S_WAIT: begin
               if (bus.spi_done)   r_err_flag <= 1'b0;
               else if (w_timeout) r_err_flag <= 1'b1;
               else                r_timer    <= r_timer + 16'd1;
            end
            S_ACK: begin
               r_last_grant <= r_grant_id;
               r_gap_cnt    <= 16'd0;
            end
            S_GAP: if (!w_gap_done) r_gap_cnt <= r_gap_cnt + 16'd1;
            default: ;
         endcase
      end
   end

   // Decoded from state so that reset clears them without waiting for a clock.
   assign bus.ack         = (r_state == S_ACK) ? (4'b0001 << r_grant_id) : 4'b0000;
   assign bus.err         = bus.ack & {4{r_err_flag}};
   assign bus.grant_valid = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_ACK);
   assign bus.spi_start   = (r_state == S_START) && !bus.spi_busy;
   assign bus.grant_id    = r_grant_id;
   assign bus.spi_sel     = r_grant_id;
   assign bus.spi_word    = r_spi_word;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: vector table plus hand-written corner sequences.
module tb_spi_req_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_req_arbiter_if bus ();

   spi_req_arbiter #(.TIMEOUT_CYC(64), .GAP_CYC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] wdata;
      int          done_dly;
      logic [1:0]  exp_id;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_start(input string name, output int waited);
      waited = 0;
      while (bus.spi_start !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      chk({name, " start seen"}, bus.spi_start, 1'b1);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.req      = 4'b0;
      bus.wdata    = 64'd0;
      bus.spi_busy = 1'b0;
      bus.spi_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic finish_txn(input string name, input logic [3:0] exp_ack, input logic [3:0] exp_err);
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
      chk({name, " ack"}, bus.ack, exp_ack);
      chk({name, " err"}, bus.err, exp_err);
      bus.req = 4'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int ack_cyc;
      logic [1:0] exp_order [5];

      vecs[0] = '{4'b0001, 64'h0000_0000_0000_A5C3, 5, 2'd0, 16'hA5C3};
      vecs[1] = '{4'b1111, 64'h4444_3333_2222_1111, 1, 2'd1, 16'h2222};
      vecs[2] = '{4'b0101, 64'h0000_5A5A_1234_7E7E, 3, 2'd2, 16'h5A5A};
      vecs[3] = '{4'b0011, 64'hFFFF_EEEE_C0DE_0BAD, 2, 2'd0, 16'h0BAD};
      vecs[4] = '{4'b1000, 64'hD00D_0000_0000_0000, 4, 2'd3, 16'hD00D};
      vecs[5] = '{4'b1010, 64'hCAFE_0000_B0B0_0000, 5, 2'd1, 16'hB0B0};
      vecs[6] = '{4'b0010, 64'h0000_0000_1357_FFFF, 1, 2'd1, 16'h1357};
      vecs[7] = '{4'b1001, 64'h8642_0000_0000_9753, 6, 2'd3, 16'h8642};
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      // Reset values
      do_reset();
      chk("rst ack", bus.ack, 4'b0);
      chk("rst err", bus.err, 4'b0);
      chk("rst grant_valid", bus.grant_valid, 1'b0);
      chk("rst grant_id", bus.grant_id, 2'd0);
      chk("rst spi_start", bus.spi_start, 1'b0);
      chk("rst spi_word", bus.spi_word, 16'h0);
      chk("rst spi_sel", bus.spi_sel, 2'd0);

      // Vector table: round-robin winner, latched word, done-to-ack timing
      for (int i = 0; i < 8; i++) begin
         bus.req   = vecs[i].req;
         bus.wdata = vecs[i].wdata;
         @(negedge clk);
         chk($sformatf("v%0d spi_start", i), bus.spi_start, 1'b1);
         chk($sformatf("v%0d grant_valid", i), bus.grant_valid, 1'b1);
         chk($sformatf("v%0d grant_id", i), bus.grant_id, vecs[i].exp_id);
         chk($sformatf("v%0d spi_sel", i), bus.spi_sel, vecs[i].exp_id);
         chk($sformatf("v%0d spi_word", i), bus.spi_word, vecs[i].exp_word);
         for (int d = 0; d < vecs[i].done_dly; d++) begin
            @(negedge clk);
            chk($sformatf("v%0d wait ack", i), bus.ack, 4'b0);
         end
         bus.spi_done = 1'b1;
         @(negedge clk);
         bus.spi_done = 1'b0;
         chk($sformatf("v%0d ack", i), bus.ack, 4'b0001 << vecs[i].exp_id);
         chk($sformatf("v%0d err", i), bus.err, 4'b0);
         chk($sformatf("v%0d word at ack", i), bus.spi_word, vecs[i].exp_word);
         bus.req = 4'b0;
         @(negedge clk);
         chk($sformatf("v%0d gap ack", i), bus.ack, 4'b0);
         chk($sformatf("v%0d gap grant_valid", i), bus.grant_valid, 1'b0);
         repeat (2) @(negedge clk);
      end

      // All four requesting continuously: order 0,1,2,3,0 with ack+gap spacing
      do_reset();
      bus.req   = 4'b1111;
      bus.wdata = 64'h0004_0003_0002_0001;
      ack_cyc   = 0;
      for (int k = 0; k < 5; k++) begin
         wait_start($sformatf("rr%0d", k), w);
         chk($sformatf("rr%0d grant_id", k), bus.grant_id, exp_order[k]);
         chk($sformatf("rr%0d spi_word", k), bus.spi_word, 16'(exp_order[k]) + 16'd1);
         if (k > 0) chk($sformatf("rr%0d ack-to-start cycles", k), cyc - ack_cyc, 4);
         repeat (2) @(negedge clk);
         bus.spi_done = 1'b1;
         @(negedge clk);
         bus.spi_done = 1'b0;
         chk($sformatf("rr%0d ack", k), bus.ack, 4'b0001 << exp_order[k]);
         ack_cyc = cyc;
      end
      bus.req = 4'b0;
      repeat (3) @(negedge clk);

      // Timeout: 64 WAIT cycles, ack and err together, next requester after gap
      do_reset();
      bus.req = 4'b0110;
      wait_start("to", w);
      chk("to grant_id", bus.grant_id, 2'd1);
      w = 0;
      while (bus.ack === 4'b0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("to start-to-ack cycles", w, 65);
      chk("to ack", bus.ack, 4'b0010);
      chk("to err", bus.err, 4'b0010);
      bus.req = 4'b0100;
      wait_start("to next", w);
      chk("to next ack-to-start cycles", w, 4);
      chk("to next grant_id", bus.grant_id, 2'd2);
      @(negedge clk);
      finish_txn("to next", 4'b0100, 4'b0000);

      // spi_done on the last WAIT cycle beats the timeout
      bus.req = 4'b0001;
      wait_start("tie", w);
      chk("tie grant_id", bus.grant_id, 2'd0);
      repeat (64) @(negedge clk);
      chk("tie pre ack", bus.ack, 4'b0);
      finish_txn("tie", 4'b0001, 4'b0000);

      // Serializer busy for 10 cycles after grant
      bus.spi_busy = 1'b1;
      bus.req      = 4'b1000;
      @(negedge clk);
      chk("busy grant_valid", bus.grant_valid, 1'b1);
      chk("busy grant_id", bus.grant_id, 2'd3);
      for (int b = 0; b < 10; b++) begin
         chk($sformatf("busy c%0d spi_start", b), bus.spi_start, 1'b0);
         @(negedge clk);
      end
      bus.spi_busy = 1'b0;
      #1;
      chk("busy release spi_start", bus.spi_start, 1'b1);
      @(negedge clk);
      chk("busy after start", bus.spi_start, 1'b0);
      finish_txn("busy", 4'b1000, 4'b0000);

      // Reset during WAIT, then during START
      bus.req   = 4'b0100;
      bus.wdata = 64'h0000_1111_0000_0000;
      @(negedge clk);
      @(negedge clk);
      chk("rw pre grant_valid", bus.grant_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("rw grant_valid", bus.grant_valid, 1'b0);
      chk("rw spi_word", bus.spi_word, 16'h0);
      chk("rw grant_id", bus.grant_id, 2'd0);
      chk("rw spi_sel", bus.spi_sel, 2'd0);
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
      chk("rw ack", bus.ack, 4'b0);
      chk("rw err", bus.err, 4'b0);
      bus.req   = 4'b1001;
      bus.wdata = 64'h7777_0000_0000_2468;
      rst       = 1'b0;
      @(negedge clk);
      chk("rw regrant id", bus.grant_id, 2'd0);
      chk("rw regrant spi_start", bus.spi_start, 1'b1);
      rst = 1'b1;
      #1;
      chk("rs async spi_start", bus.spi_start, 1'b0);
      bus.req = 4'b0;
      @(negedge clk);
      chk("rs ack", bus.ack, 4'b0);
      rst = 1'b0;
      @(negedge clk);

      // Word sampled at grant only; dropped req still acked; stray done ignored
      bus.req   = 4'b0100;
      bus.wdata = 64'h0000_BEEF_0000_0000;
      @(negedge clk);
      chk("hold grant_id", bus.grant_id, 2'd2);
      chk("hold spi_word", bus.spi_word, 16'hBEEF);
      bus.wdata = 64'hFFFF_1234_FFFF_FFFF;
      bus.req   = 4'b0000;
      repeat (3) @(negedge clk);
      chk("hold word in wait", bus.spi_word, 16'hBEEF);
      finish_txn("hold", 4'b0100, 4'b0000);
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
      chk("idle done ack", bus.ack, 4'b0);
      chk("idle done grant_valid", bus.grant_valid, 1'b0);
      @(negedge clk);
      chk("idle done ack later", bus.ack, 4'b0);
      chk("idle done err later", bus.err, 4'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum WAIT-state cycles before a transaction is aborted.
REQ-002 Parameter GAP_CYC, default 2: idle cycles inserted after each ACK before the next grant; 0 is legal.
REQ-003 clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  level request per requester; held high until that requester's ack.
REQ-006 wdata  input  64  request word; requester i occupies bits [16i+15:16i].
REQ-007 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-008 err  output  4  one-cycle timeout flag, coincident with ack, same requester bit.
REQ-009 grant_valid  output  1  high from grant through the ACK cycle.
REQ-010 grant_id  output  2  index of the current or most recent grantee.
REQ-011 spi_start  output  1  one-cycle start pulse to the SPI word serializer.
REQ-012 spi_word  output  16  word to serialize; stable from START until the ACK cycle.
REQ-013 spi_sel  output  2  slave select index; always equal to grant_id.
REQ-014 spi_busy  input  1  serializer busy; no start is issued while it is high.
REQ-015 spi_done  input  1  serializer one-cycle word-complete pulse.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT, ACK and GAP, encoded in a 3-bit register.
REQ-017 IDLE with any req bit high: register the round-robin winner into grant_id, latch its wdata slice into spi_word, set grant_valid, and go to START next cycle.
REQ-018 Round-robin SHALL search from last_grant+1 upward modulo 4; the first requester with req high wins.
REQ-019 START: assert spi_start for exactly one cycle when spi_busy is low, then go to WAIT; while spi_busy is high, hold START with spi_start low.
REQ-020 WAIT: a 16-bit timer clears on entry and increments each cycle; on spi_done go to ACK with err clear.
REQ-021 WAIT: if the timer reaches TIMEOUT_CYC-1 without spi_done, go to ACK with err set.
REQ-022 When spi_done and the timeout coincide in the same cycle, spi_done SHALL win and err stays clear.
REQ-023 ACK: pulse ack[grant_id] for one cycle, plus err[grant_id] on timeout; set last_grant to grant_id.
REQ-024 ACK exit: go to GAP if GAP_CYC>0, otherwise to IDLE; grant_valid clears on leaving ACK.
REQ-025 GAP: hold for exactly GAP_CYC cycles, then go to IDLE; req is ignored during GAP.
REQ-026 Grant-to-start latency SHALL be 1 cycle when spi_busy is low.
REQ-027 wdata SHALL be sampled only at grant; later changes are ignored.
REQ-028 A requester dropping req mid-transaction does not abort it; its ack still pulses.
REQ-029 spi_done outside WAIT SHALL be ignored.
REQ-030 ack and err SHALL be zero outside ACK, and at most one ack bit is high in any cycle.
REQ-031 Unused FSM encodings SHALL return to IDLE on the next clock.

Reset
REQ-032 On rst: state IDLE; ack, err, spi_start, grant_valid = 0; spi_word = 0; grant_id = 0; spi_sel = 0; timers = 0; last_grant = 3, so requester 0 has first priority.
REQ-033 rst asserted mid-transaction SHALL abort it immediately with no ack, and spi_start SHALL drop asynchronously.

Verification
REQ-034 Single request: req=0001, wdata[15:0]=A5C3, spi_done 5 cycles after start -> spi_start one cycle after grant; spi_word=A5C3; spi_sel=0; ack=0001 one cycle after done; err=0.
REQ-035 All four requesting continuously -> grant order 0,1,2,3,0; consecutive grants separated by ack + GAP_CYC(2) idle cycles.
REQ-036 spi_done never asserted -> ack and err both pulse on the same bit after 64 WAIT cycles; the next requester is granted after the gap.
REQ-037 spi_busy held high 10 cycles after grant -> spi_start issued on the first cycle busy is low; no earlier start.
REQ-038 rst pulsed during WAIT -> all outputs go 0 and no ack; after reset, req=1000|0001 grants requester 0 first.
REQ-039 wdata changed and req dropped after grant -> the original word is transmitted and ack still pulses; a spi_done pulse in IDLE is ignored.
